// File: rtl/ahbl_to_apb.sv
// AHB-Lite slave to APB3 master bridge, one outstanding transfer.
// Each accepted AHB address phase becomes one APB SETUP/ACCESS sequence.
module ahbl_to_apb #(
    parameter int unsigned W_HADDR = 32,
    parameter int unsigned W_PADDR = 16,
    parameter int unsigned W_DATA  = 32
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               ahbls_hready,
    output logic               ahbls_hready_resp,
    output logic               ahbls_hresp,
    input  logic [W_HADDR-1:0] ahbls_haddr,
    input  logic               ahbls_hwrite,
    input  logic [1:0]         ahbls_htrans,
    input  logic [2:0]         ahbls_hsize,
    input  logic [2:0]         ahbls_hburst,
    input  logic [3:0]         ahbls_hprot,
    input  logic               ahbls_hmastlock,
    input  logic [W_DATA-1:0]  ahbls_hwdata,
    output logic [W_DATA-1:0]  ahbls_hrdata,

    output logic [W_PADDR-1:0] apbm_paddr,
    output logic               apbm_psel,
    output logic               apbm_penable,
    output logic               apbm_pwrite,
    output logic [W_DATA-1:0]  apbm_pwdata,
    input  logic               apbm_pready,
    input  logic [W_DATA-1:0]  apbm_prdata,
    input  logic               apbm_pslverr
);

    // hsize encoding of a full-width transfer: log2(W_DATA/8)
    localparam logic [2:0] HSIZE_FULL = (W_DATA == 64) ? 3'd3 : 3'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_DATA = 3'd1,
        S_SETUP   = 3'd2,
        S_ACCESS  = 3'd3,
        S_ERR1    = 3'd4,
        S_ERR2    = 3'd5
    } state_t;

    state_t state;
    state_t state_next;
    state_t addr_state;
    logic   accept;
    logic   load_addr;

    logic unused;
    assign unused = ^{ahbls_haddr[W_HADDR-1:W_PADDR], ahbls_htrans[0],
                      ahbls_hburst, ahbls_hprot, ahbls_hmastlock};

    assign ahbls_hrdata = apbm_prdata;

    // Destination state for an address phase offered this cycle
    always_comb begin
        accept = ahbls_hready && ahbls_htrans[1];
        if (!accept) begin
            addr_state = S_IDLE;
        end else if (!ahbls_hwrite) begin
            addr_state = S_SETUP;
        end else if (ahbls_hsize == HSIZE_FULL) begin
            addr_state = S_WR_DATA;
        end else begin
            addr_state = S_ERR1;
        end
    end

    always_comb begin
        state_next        = state;
        ahbls_hready_resp = 1'b1;
        ahbls_hresp       = 1'b0;
        load_addr         = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = addr_state;
                load_addr  = accept;
            end
            S_WR_DATA: begin
                ahbls_hready_resp = 1'b0;
                state_next        = S_SETUP;
            end
            S_SETUP: begin
                ahbls_hready_resp = 1'b0;
                state_next        = S_ACCESS;
            end
            S_ACCESS: begin
                if (!apbm_pready) begin
                    ahbls_hready_resp = 1'b0;
                end else if (apbm_pslverr) begin
                    // This cycle is the first of the two-cycle ERROR response
                    ahbls_hready_resp = 1'b0;
                    ahbls_hresp       = 1'b1;
                    state_next        = S_ERR2;
                end else begin
                    state_next = addr_state;
                    load_addr  = accept;
                end
            end
            S_ERR1: begin
                ahbls_hready_resp = 1'b0;
                ahbls_hresp       = 1'b1;
                state_next        = S_ERR2;
            end
            S_ERR2: begin
                ahbls_hresp = 1'b1;
                state_next  = addr_state;
                load_addr   = accept;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // APB outputs registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            apbm_psel    <= 1'b0;
            apbm_penable <= 1'b0;
            apbm_paddr   <= '0;
            apbm_pwrite  <= 1'b0;
            apbm_pwdata  <= '0;
        end else begin
            apbm_psel    <= (state_next == S_SETUP) || (state_next == S_ACCESS);
            apbm_penable <= (state_next == S_ACCESS);
            if (load_addr) begin
                apbm_paddr  <= ahbls_haddr[W_PADDR-1:0];
                apbm_pwrite <= ahbls_hwrite;
            end
            if (state == S_WR_DATA) begin
                apbm_pwdata <= ahbls_hwdata;
            end
        end
    end

endmodule

// File: tb/tb_ahbl_to_apb.sv
// Self-checking bench for ahbl_to_apb: directed vector table, reset corner
// cases, and random transactions checked against a transaction-level model.
module tb_ahbl_to_apb;

    logic        clk;
    logic        rst;
    logic        ahbls_hready;
    logic        ahbls_hready_resp;
    logic        ahbls_hresp;
    logic [31:0] ahbls_haddr;
    logic        ahbls_hwrite;
    logic [1:0]  ahbls_htrans;
    logic [2:0]  ahbls_hsize;
    logic [2:0]  ahbls_hburst;
    logic [3:0]  ahbls_hprot;
    logic        ahbls_hmastlock;
    logic [31:0] ahbls_hwdata;
    logic [31:0] ahbls_hrdata;
    logic [15:0] apbm_paddr;
    logic        apbm_psel;
    logic        apbm_penable;
    logic        apbm_pwrite;
    logic [31:0] apbm_pwdata;
    logic        apbm_pready;
    logic [31:0] apbm_prdata;
    logic        apbm_pslverr;

    // Single slave on the bus: bus HREADY is this slave's response
    assign ahbls_hready = ahbls_hready_resp;

    ahbl_to_apb dut (
        .clk               (clk),
        .rst               (rst),
        .ahbls_hready      (ahbls_hready),
        .ahbls_hready_resp (ahbls_hready_resp),
        .ahbls_hresp       (ahbls_hresp),
        .ahbls_haddr       (ahbls_haddr),
        .ahbls_hwrite      (ahbls_hwrite),
        .ahbls_htrans      (ahbls_htrans),
        .ahbls_hsize       (ahbls_hsize),
        .ahbls_hburst      (ahbls_hburst),
        .ahbls_hprot       (ahbls_hprot),
        .ahbls_hmastlock   (ahbls_hmastlock),
        .ahbls_hwdata      (ahbls_hwdata),
        .ahbls_hrdata      (ahbls_hrdata),
        .apbm_paddr        (apbm_paddr),
        .apbm_psel         (apbm_psel),
        .apbm_penable      (apbm_penable),
        .apbm_pwrite       (apbm_pwrite),
        .apbm_pwdata       (apbm_pwdata),
        .apbm_pready       (apbm_pready),
        .apbm_prdata       (apbm_prdata),
        .apbm_pslverr      (apbm_pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic        slverr;
        int          gap;
        int          exp_cycles;
        logic        exp_err;
        logic        exp_apb;
    } txn_t;

    int errors = 0;
    int checks = 0;

    txn_t q[$];
    txn_t dp;
    txn_t pend;
    logic have_dp = 1'b0;
    logic pend_v  = 1'b0;
    int   dp_cyc, slv_wait, psel_cnt, pen_cnt, apb_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic w, input logic [31:0] a, input logic [2:0] s,
                                input logic [31:0] wd, input logic [31:0] rd, input int wt,
                                input logic se, input int g, input int ec, input logic ee,
                                input logic ea);
        txn_t t;
        t.write = w; t.addr = a; t.size = s; t.wdata = wd; t.rdata = rd;
        t.waits = wt; t.slverr = se; t.gap = g;
        t.exp_cycles = ec; t.exp_err = ee; t.exp_apb = ea;
        return t;
    endfunction

    // Transaction-level reference: data-phase length and response from the bridge rules
    function automatic txn_t model(input txn_t t);
        txn_t r = t;
        logic sub = t.write && (t.size != 3'd2);
        r.exp_apb = !sub;
        r.exp_err = sub || t.slverr;
        if (sub) r.exp_cycles = 2;
        else     r.exp_cycles = (t.write ? 3 : 2) + t.waits + (t.slverr ? 1 : 0);
        return r;
    endfunction

    task automatic drive_idle_addr();
        ahbls_htrans    = 2'(($urandom_range(0, 1)));
        ahbls_haddr     = $urandom;
        ahbls_hwrite    = 1'($urandom_range(0, 1));
        ahbls_hsize     = 3'($urandom_range(0, 2));
        ahbls_hburst    = 3'($urandom);
        ahbls_hprot     = 4'($urandom);
        ahbls_hmastlock = 1'($urandom_range(0, 1));
    endtask

    // Cycle-driven AHB master + APB slave; consumes q until all data phases finish
    task automatic run_queue();
        int budget = 20000;
        logic exp_hresp;
        while ((q.size() > 0 || have_dp || pend_v) && budget > 0) begin
            @(negedge clk);
            budget--;
            if (pend_v) begin
                dp = pend; have_dp = 1'b1; pend_v = 1'b0;
                dp_cyc = 0; slv_wait = dp.waits;
                psel_cnt = 0; pen_cnt = 0; apb_cnt = 0;
                ahbls_hwdata = dp.wdata;
            end
            apbm_pslverr = 1'b0;
            apbm_prdata  = $urandom;
            if (apbm_psel && apbm_penable) begin
                if (slv_wait > 0) begin
                    apbm_pready = 1'b0;
                    slv_wait--;
                end else begin
                    apbm_pready  = 1'b1;
                    apbm_pslverr = dp.slverr;
                    apbm_prdata  = dp.rdata;
                end
            end else begin
                apbm_pready  = 1'($urandom_range(0, 1));
                apbm_pslverr = 1'($urandom_range(0, 1));
            end
            #1;
            if (have_dp) begin
                dp_cyc++;
                if (apbm_psel) begin
                    psel_cnt++;
                    if (dp.write) check("pwdata_hold", 64'(apbm_pwdata), 64'(dp.wdata));
                end
                if (apbm_penable) pen_cnt++;
                if (apbm_psel && apbm_penable && apbm_pready) begin
                    apb_cnt++;
                    check("paddr", 64'(apbm_paddr), 64'(dp.addr[15:0]));
                    check("pwrite", 64'(apbm_pwrite), 64'(dp.write));
                end
                exp_hresp = dp.exp_err && (dp_cyc >= dp.exp_cycles - 1);
                check("hresp", 64'(ahbls_hresp), 64'(exp_hresp));
                if (ahbls_hready_resp) begin
                    check("dphase_cycles", 64'(dp_cyc), 64'(dp.exp_cycles));
                    check("apb_count", 64'(apb_cnt), 64'(dp.exp_apb ? 1 : 0));
                    check("psel_cycles", 64'(psel_cnt), 64'(dp.exp_apb ? dp.waits + 2 : 0));
                    check("penable_cycles", 64'(pen_cnt), 64'(dp.exp_apb ? dp.waits + 1 : 0));
                    if (!dp.write && !dp.exp_err)
                        check("hrdata", 64'(ahbls_hrdata), 64'(dp.rdata));
                    have_dp = 1'b0;
                end
            end else begin
                check("idle_ready", 64'({ahbls_hready_resp, ahbls_hresp}), 64'(2'b10));
            end
            drive_idle_addr();
            if (ahbls_hready_resp && q.size() > 0) begin
                if (q[0].gap > 0) begin
                    q[0].gap--;
                end else begin
                    pend = q.pop_front();
                    pend_v = 1'b1;
                    ahbls_htrans = {1'b1, 1'($urandom_range(0, 1))};
                    ahbls_haddr  = pend.addr;
                    ahbls_hwrite = pend.write;
                    ahbls_hsize  = pend.size;
                end
            end
        end
        if (budget == 0) begin
            check("run_timeout", 64'(1), 64'(0));
            q.delete(); have_dp = 1'b0; pend_v = 1'b0;
        end
    endtask

    txn_t vec[10];

    initial begin
        // write, addr, size, wdata, rdata, waits, slverr, gap, exp_cycles, exp_err, exp_apb
        vec[0] = mk(0, 32'h0000_1234, 3'd2, 32'h0,         32'hDEAD_BEEF, 0, 0, 1, 2, 0, 1);
        vec[1] = mk(1, 32'h0000_0010, 3'd2, 32'hCAFE_F00D, 32'h0,         2, 0, 1, 5, 0, 1);
        vec[2] = mk(0, 32'h0000_0020, 3'd2, 32'h0,         32'h1111_2222, 0, 1, 1, 3, 1, 1);
        vec[3] = mk(1, 32'h0000_0030, 3'd0, 32'h5555_AAAA, 32'h0,         0, 0, 1, 2, 1, 0);
        vec[4] = mk(0, 32'hABCD_4000, 3'd2, 32'h0,         32'h0BAD_CAFE, 0, 0, 1, 2, 0, 1);
        vec[5] = mk(1, 32'h0000_4004, 3'd2, 32'h1234_5678, 32'h0,         0, 0, 0, 3, 0, 1);
        vec[6] = mk(0, 32'h0000_4008, 3'd1, 32'h0,         32'h8765_4321, 1, 0, 0, 3, 0, 1);
        vec[7] = mk(1, 32'h0000_400C, 3'd2, 32'hFEED_0001, 32'h0,         1, 1, 0, 5, 1, 1);
        vec[8] = mk(1, 32'h0000_4010, 3'd1, 32'h0000_FFFF, 32'h0,         0, 0, 0, 2, 1, 0);
        vec[9] = mk(0, 32'h0000_4014, 3'd2, 32'h0,         32'hA5A5_5A5A, 3, 0, 0, 5, 0, 1);

        rst = 1'b1;
        ahbls_hwdata = 32'h0;
        apbm_pready = 1'b0; apbm_pslverr = 1'b0; apbm_prdata = 32'h0;
        drive_idle_addr();
        ahbls_htrans = 2'b10; ahbls_hwrite = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_psel", 64'(apbm_psel), 64'(0));
        check("rst_penable", 64'(apbm_penable), 64'(0));
        check("rst_pwrite", 64'(apbm_pwrite), 64'(0));
        check("rst_paddr", 64'(apbm_paddr), 64'(0));
        check("rst_pwdata", 64'(apbm_pwdata), 64'(0));
        check("rst_hready_resp", 64'(ahbls_hready_resp), 64'(1));
        check("rst_hresp", 64'(ahbls_hresp), 64'(0));
        ahbls_htrans = 2'b00;
        rst = 1'b0;

        // Reset while a read is stalled in ACCESS aborts it
        @(negedge clk);
        ahbls_htrans = 2'b10; ahbls_haddr = 32'h0000_55AA;
        ahbls_hwrite = 1'b0; ahbls_hsize = 3'd2; apbm_pready = 1'b0;
        @(negedge clk);
        ahbls_htrans = 2'b00;
        @(negedge clk);
        #1;
        check("abort_in_access", 64'({apbm_psel, apbm_penable, ahbls_hready_resp}), 64'(3'b110));
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("abort_psel", 64'(apbm_psel), 64'(0));
        check("abort_penable", 64'(apbm_penable), 64'(0));
        check("abort_hready_resp", 64'(ahbls_hready_resp), 64'(1));
        check("abort_hresp", 64'(ahbls_hresp), 64'(0));
        rst = 1'b0;
        q.push_back(mk(0, 32'h0000_0444, 3'd2, 32'h0, 32'h600D_DA7A, 0, 0, 0, 2, 0, 1));
        run_queue();

        // Directed table
        for (int i = 0; i < 10; i++) q.push_back(vec[i]);
        run_queue();

        // Random transactions against the reference model
        for (int i = 0; i < 60; i++) begin
            txn_t t;
            t.write  = 1'($urandom_range(0, 1));
            t.addr   = $urandom;
            t.size   = t.write ? (($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 1)) : 3'd2)
                               : 3'($urandom_range(0, 2));
            t.wdata  = $urandom;
            t.rdata  = $urandom;
            t.waits  = int'($urandom_range(0, 3));
            t.slverr = ($urandom_range(0, 5) == 0);
            t.gap    = int'($urandom_range(0, 2));
            q.push_back(model(t));
        end
        run_queue();

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
